// File: rtl/inst_sequencer.sv
// inst_sequencer: on-chip instruction generator for one output tile of the PE core.
// For each kernel position (kij) it streams weights into the IFIFO, loads the kernel,
// fills L0 with activations, executes, and drains the OFIFO into psum memory. It then
// reads psum memory back and accumulates every output pixel (onij) in the SFU.
// Ports:
//   clk          clock, all flops on posedge
//   reset        asynchronous, active-low; forces IDLE and the idle instruction word
//   start        one-cycle request, sampled only in IDLE
//   ofifo_valid  core OFIFO holds a full row of psums
//   inst[33:0]   instruction word to core.inst
//   sfp_clr      one-cycle SFU accumulator clear before each onij
//   out_valid    one-cycle: SFU output holds the final value for onij
//   onij[3:0]    output index accompanying out_valid
//   busy         high outside IDLE
//   done         one-cycle pulse after the last onij
module inst_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [33:0] inst,
  output logic        sfp_clr,
  output logic        out_valid,
  output logic [3:0]  onij,
  output logic        busy,
  output logic        done
);

  localparam int unsigned ROW      = 8;
  localparam int unsigned COL      = 8;
  localparam int unsigned LEN_NIJ  = 36;
  localparam int unsigned I_DIM    = 6;
  localparam int unsigned O_DIM    = 4;
  localparam int unsigned KSIZE    = 3;
  localparam int unsigned LEN_KIJ  = KSIZE * KSIZE;
  localparam int unsigned LEN_ONIJ = O_DIM * O_DIM;
  localparam int unsigned GAP      = 10;
  localparam int unsigned W_BASE   = 'h400;
  localparam int unsigned A_BASE   = 'h000;
  localparam int unsigned AW       = 11;
  localparam int unsigned T_W      = 6;

  localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;

  typedef struct packed {
    logic          acc;
    logic          cen_pmem;
    logic          wen_pmem;
    logic [AW-1:0] a_pmem;
    logic          cen_xmem;
    logic          wen_xmem;
    logic [AW-1:0] a_xmem;
    logic          ofifo_rd;
    logic          ififo_wr;
    logic          ififo_rd;
    logic          l0_rd;
    logic          l0_wr;
    logic          execute;
    logic          load;
  } inst_t;

  typedef enum logic [3:0] {
    S_IDLE, S_W_IFIFO, S_K_LOAD, S_K_DRAIN, S_K_GAP, S_A_L0, S_EXEC,
    S_OFIFO, S_ACC_CLR, S_ACC_RD, S_ACC_OUT, S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [T_W-1:0] t_q, t_d;
  logic [3:0]     kij_q, kij_d;
  logic [5:0]     n_q, n_d;
  logic [3:0]     onij_q, onij_d;
  logic [1:0]     ox_q, ox_d, oy_q, oy_d;
  logic [1:0]     kx_q, kx_d, ky_q, ky_d;
  inst_t          inst_q, inst_d;
  logic           sfp_clr_q, sfp_clr_d;
  logic           out_valid_q, out_valid_d;
  logic [3:0]     onij_out_q, onij_out_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [AW-1:0]  acc_addr;
  logic [AW-1:0]  ofifo_addr;

  // psum addresses: accumulation read walks the kernel window, drain writes row by row
  always_comb begin
    acc_addr   = AW'(LEN_NIJ * 32'(t_q) + (32'(oy_q) + 32'(ky_q)) * I_DIM
                     + 32'(ox_q) + 32'(kx_q));
    ofifo_addr = AW'(LEN_NIJ * 32'(kij_q) + 32'(n_q));
  end

  // next state, counters and instruction word
  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    kij_d       = kij_q;
    n_d         = n_q;
    onij_d      = onij_q;
    ox_d        = ox_q;
    oy_d        = oy_q;
    kx_d        = kx_q;
    ky_d        = ky_q;
    inst_d      = inst_t'(IDLE_WORD);
    sfp_clr_d   = 1'b0;
    out_valid_d = 1'b0;
    onij_out_d  = '0;
    done_d      = 1'b0;
    busy_d      = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_W_IFIFO;
          t_d     = '0;
          kij_d   = '0;
          n_d     = '0;
          onij_d  = '0;
          ox_d    = '0;
          oy_d    = '0;
          kx_d    = '0;
          ky_d    = '0;
        end
      end
      S_W_IFIFO: begin
        inst_d.ififo_wr = 1'b1;
        inst_d.cen_xmem = 1'b0;
        inst_d.a_xmem   = AW'(W_BASE + 32'(t_q));
        if (t_q == T_W'(COL - 1)) begin
          state_d = S_K_LOAD;
          t_d     = '0;
        end else t_d = t_q + T_W'(1);
      end
      S_K_LOAD: begin
        inst_d.ififo_rd = 1'b1;
        inst_d.load     = 1'b1;
        if (t_q == T_W'(COL - 1)) begin
          state_d = S_K_DRAIN;
          t_d     = '0;
        end else t_d = t_q + T_W'(1);
      end
      S_K_DRAIN: begin
        inst_d.load = 1'b1;
        if (t_q == T_W'(COL - 1)) begin
          state_d = S_K_GAP;
          t_d     = '0;
        end else t_d = t_q + T_W'(1);
      end
      S_K_GAP: begin
        inst_d.load = 1'b1;
        if (t_q == T_W'(GAP - 1)) begin
          state_d = S_A_L0;
          t_d     = '0;
        end else t_d = t_q + T_W'(1);
      end
      S_A_L0: begin
        // one extra word: the last address read is a_base + len_nij
        inst_d.l0_wr    = 1'b1;
        inst_d.cen_xmem = 1'b0;
        inst_d.a_xmem   = AW'(A_BASE + 32'(t_q));
        if (t_q == T_W'(LEN_NIJ)) begin
          state_d = S_EXEC;
          t_d     = '0;
        end else t_d = t_q + T_W'(1);
      end
      S_EXEC: begin
        inst_d.l0_rd   = 1'b1;
        inst_d.execute = 1'b1;
        if (t_q == T_W'(LEN_NIJ + ROW + COL - 1)) begin
          state_d = S_OFIFO;
          t_d     = '0;
          n_d     = '0;
        end else t_d = t_q + T_W'(1);
      end
      S_OFIFO: begin
        // stall on an empty OFIFO: idle word, read index held
        if (ofifo_valid) begin
          inst_d.ofifo_rd = 1'b1;
          inst_d.cen_pmem = 1'b0;
          inst_d.wen_pmem = 1'b0;
          inst_d.a_pmem   = ofifo_addr;
          if (n_q == 6'(LEN_NIJ - 1)) begin
            n_d = '0;
            t_d = '0;
            if (kij_q == 4'(LEN_KIJ - 1)) state_d = S_ACC_CLR;
            else begin
              kij_d   = kij_q + 4'(1);
              state_d = S_W_IFIFO;
            end
          end else n_d = n_q + 6'(1);
        end
      end
      S_ACC_CLR: begin
        sfp_clr_d = 1'b1;
        state_d   = S_ACC_RD;
        t_d       = '0;
        kx_d      = '0;
        ky_d      = '0;
      end
      S_ACC_RD: begin
        // acc trails the read by one cycle, so the final cycle only accumulates
        inst_d.acc = (t_q != '0);
        if (t_q != T_W'(LEN_KIJ)) begin
          inst_d.cen_pmem = 1'b0;
          inst_d.a_pmem   = acc_addr;
          if (kx_q == 2'(KSIZE - 1)) begin
            kx_d = '0;
            ky_d = ky_q + 2'(1);
          end else kx_d = kx_q + 2'(1);
          t_d = t_q + T_W'(1);
        end else state_d = S_ACC_OUT;
      end
      S_ACC_OUT: begin
        out_valid_d = 1'b1;
        onij_out_d  = onij_q;
        if (onij_q == 4'(LEN_ONIJ - 1)) state_d = S_DONE;
        else begin
          onij_d  = onij_q + 4'(1);
          state_d = S_ACC_CLR;
          if (ox_q == 2'(O_DIM - 1)) begin
            ox_d = '0;
            oy_d = oy_q + 2'(1);
          end else ox_d = ox_q + 2'(1);
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state, counters and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      t_q         <= '0;
      kij_q       <= '0;
      n_q         <= '0;
      onij_q      <= '0;
      ox_q        <= '0;
      oy_q        <= '0;
      kx_q        <= '0;
      ky_q        <= '0;
      inst_q      <= inst_t'(IDLE_WORD);
      sfp_clr_q   <= 1'b0;
      out_valid_q <= 1'b0;
      onij_out_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      kij_q       <= kij_d;
      n_q         <= n_d;
      onij_q      <= onij_d;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
      kx_q        <= kx_d;
      ky_q        <= ky_d;
      inst_q      <= inst_d;
      sfp_clr_q   <= sfp_clr_d;
      out_valid_q <= out_valid_d;
      onij_out_q  <= onij_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign inst      = inst_q;
  assign sfp_clr   = sfp_clr_q;
  assign out_valid = out_valid_q;
  assign onij      = onij_out_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Testbench for inst_sequencer: full-run traces against a phase-list reference model,
// a table of hand-derived words for a run with an OFIFO stall, random OFIFO stalls,
// ignored starts, mid-run asynchronous reset and a repeat-run trace comparison.
module tb_inst_sequencer;

  localparam int MAXC = 4096;
  localparam logic [33:0] IDLE = 34'h1_800C_0000;
  localparam logic [6:0] WIF = 7'b0100000;
  localparam logic [6:0] KLD = 7'b0010001;
  localparam logic [6:0] LD  = 7'b0000001;
  localparam logic [6:0] L0W = 7'b0000100;
  localparam logic [6:0] EXE = 7'b0001010;
  localparam logic [6:0] OFR = 7'b1000000;

  typedef struct packed {
    logic [33:0] inst;
    logic        clr;
    logic        ov;
    logic [3:0]  onij;
    logic        busy;
    logic        done;
  } obs_t;

  typedef struct {
    int          cyc;
    bit          ofv;
    logic [33:0] inst;
    logic        clr;
    logic        ov;
    logic [3:0]  onij;
    logic        done;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        ofifo_valid;
  logic [33:0] inst;
  logic        sfp_clr;
  logic        out_valid;
  logic [3:0]  onij;
  logic        busy;
  logic        done;

  bit   vp[MAXC];
  obs_t cap[$];
  obs_t expq[$];
  obs_t ref_trace[$];
  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  inst_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .ofifo_valid(ofifo_valid),
    .inst(inst), .sfp_clr(sfp_clr), .out_valid(out_valid), .onij(onij),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [33:0] mk(bit acc, bit cenp, bit wenp, int ap,
                                     bit cenx, bit wenx, int ax, logic [6:0] lo);
    return {acc, cenp, wenp, 11'(ap), cenx, wenx, 11'(ax), lo};
  endfunction

  function automatic obs_t ob(logic [33:0] w, logic clr, logic ov, logic [3:0] o, logic dn);
    obs_t r;
    r.inst = w; r.clr = clr; r.ov = ov; r.onij = o; r.busy = 1'b1; r.done = dn;
    return r;
  endfunction

  function automatic vec_t vv(int c, bit ofv, logic [33:0] w, logic clr, logic ov,
                              logic [3:0] o, logic dn);
    vec_t r;
    r.cyc = c; r.ofv = ofv; r.inst = w; r.clr = clr; r.ov = ov; r.onij = o; r.done = dn;
    return r;
  endfunction

  function automatic obs_t sample();
    obs_t r;
    r.inst = inst; r.clr = sfp_clr; r.ov = out_valid;
    r.onij = out_valid ? onij : 4'd0;
    r.busy = busy; r.done = done;
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: the instruction stream written out phase by phase with plain arithmetic.
  task automatic build_model();
    int c;
    int n;
    expq.delete();
    for (int k = 0; k < 9; k++) begin
      for (int t = 0; t < 8; t++)   expq.push_back(ob(mk(0,1,1,0,0,1,'h400+t,WIF),0,0,0,0));
      for (int t = 0; t < 8; t++)   expq.push_back(ob(mk(0,1,1,0,1,1,0,KLD),0,0,0,0));
      for (int t = 0; t < 18; t++)  expq.push_back(ob(mk(0,1,1,0,1,1,0,LD),0,0,0,0));
      for (int t = 0; t <= 36; t++) expq.push_back(ob(mk(0,1,1,0,0,1,t,L0W),0,0,0,0));
      for (int t = 0; t < 52; t++)  expq.push_back(ob(mk(0,1,1,0,1,1,0,EXE),0,0,0,0));
      n = 0;
      while (n < 36) begin
        c = expq.size();
        if (c >= MAXC || vp[c]) begin
          expq.push_back(ob(mk(0,0,0,36*k+n,1,1,0,OFR),0,0,0,0));
          n++;
        end else expq.push_back(ob(IDLE,0,0,0,0));
      end
    end
    for (int o = 0; o < 16; o++) begin
      expq.push_back(ob(IDLE,1,0,0,0));
      for (int j = 0; j < 10; j++) begin
        if (j < 9)
          expq.push_back(ob(mk(j>=1,0,1,36*j+(o/4+j/3)*6+(o%4)+(j%3),1,1,0,0),0,0,0,0));
        else
          expq.push_back(ob(mk(1,1,1,0,1,1,0,0),0,0,0,0));
      end
      expq.push_back(ob(IDLE,0,1,4'(o),0));
    end
    expq.push_back(ob(IDLE,0,0,0,1));
  endtask

  // Pulse start, then record one observation per state cycle until done (bounded).
  task automatic run_trace(input int restart_at);
    cap.delete();
    @(negedge clk); start = 1'b1; ofifo_valid = 1'b0;
    @(posedge clk);
    for (int c = 0; c < MAXC; c++) begin
      @(negedge clk);
      start = (c == restart_at);
      ofifo_valid = vp[c];
      @(posedge clk); #1;
      cap.push_back(sample());
      if (done) break;
    end
    @(negedge clk); start = 1'b0; ofifo_valid = 1'b0;
  endtask

  task automatic compare_model(string tag);
    int m;
    chk({tag, " length"}, 64'(cap.size()), 64'(expq.size()));
    m = (cap.size() < expq.size()) ? cap.size() : expq.size();
    for (int i = 0; i < m; i++)
      chk($sformatf("%s c%0d", tag, i), 64'(cap[i]), 64'(expq[i]));
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk({tag, " idle_after"}, 64'({busy, done, inst}), 64'({1'b0, 1'b0, IDLE}));
    end
  endtask

  task automatic fill_vp(input int mode);
    for (int i = 0; i < MAXC; i++) vp[i] = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    int bc;
    int ovn;
    bit seq_ok;
    bit found;
    bit same;

    // Stall run vectors: kij=2 OFIFO starts at cycle 441; OFIFO empty for cycles 451..455.
    vecs.push_back(vv(0,    1, mk(0,1,1,0,0,1,'h400,WIF), 0,0,0,0));
    vecs.push_back(vv(7,    1, mk(0,1,1,0,0,1,'h407,WIF), 0,0,0,0));
    vecs.push_back(vv(8,    1, mk(0,1,1,0,1,1,0,KLD), 0,0,0,0));
    vecs.push_back(vv(15,   1, mk(0,1,1,0,1,1,0,KLD), 0,0,0,0));
    vecs.push_back(vv(16,   1, mk(0,1,1,0,1,1,0,LD), 0,0,0,0));
    vecs.push_back(vv(33,   1, mk(0,1,1,0,1,1,0,LD), 0,0,0,0));
    vecs.push_back(vv(34,   1, mk(0,1,1,0,0,1,0,L0W), 0,0,0,0));
    vecs.push_back(vv(70,   1, mk(0,1,1,0,0,1,36,L0W), 0,0,0,0));
    vecs.push_back(vv(71,   1, mk(0,1,1,0,1,1,0,EXE), 0,0,0,0));
    vecs.push_back(vv(122,  1, mk(0,1,1,0,1,1,0,EXE), 0,0,0,0));
    vecs.push_back(vv(123,  1, mk(0,0,0,0,1,1,0,OFR), 0,0,0,0));
    vecs.push_back(vv(441,  1, mk(0,0,0,72,1,1,0,OFR), 0,0,0,0));
    vecs.push_back(vv(450,  1, mk(0,0,0,81,1,1,0,OFR), 0,0,0,0));
    for (int i = 451; i <= 455; i++) vecs.push_back(vv(i, 0, IDLE, 0,0,0,0));
    vecs.push_back(vv(456,  1, mk(0,0,0,82,1,1,0,OFR), 0,0,0,0));
    vecs.push_back(vv(481,  1, mk(0,0,0,107,1,1,0,OFR), 0,0,0,0));
    vecs.push_back(vv(482,  1, mk(0,1,1,0,0,1,'h400,WIF), 0,0,0,0));
    vecs.push_back(vv(1436, 1, IDLE, 1,0,0,0));
    vecs.push_back(vv(1437, 1, mk(0,0,1,0,1,1,0,0), 0,0,0,0));
    vecs.push_back(vv(1438, 1, mk(1,0,1,37,1,1,0,0), 0,0,0,0));
    vecs.push_back(vv(1439, 1, mk(1,0,1,74,1,1,0,0), 0,0,0,0));
    vecs.push_back(vv(1440, 1, mk(1,0,1,114,1,1,0,0), 0,0,0,0));
    vecs.push_back(vv(1445, 1, mk(1,0,1,302,1,1,0,0), 0,0,0,0));
    vecs.push_back(vv(1446, 1, mk(1,1,1,0,1,1,0,0), 0,0,0,0));
    vecs.push_back(vv(1447, 1, IDLE, 0,1,0,0));
    vecs.push_back(vv(1501, 1, mk(1,0,1,158,1,1,0,0), 0,0,0,0));
    vecs.push_back(vv(1627, 1, IDLE, 0,1,15,0));
    vecs.push_back(vv(1628, 1, IDLE, 0,0,0,1));

    reset = 1'b0; start = 1'b0; ofifo_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_inst", 64'(inst), 64'(IDLE));
    chk("reset_others", 64'({sfp_clr, out_valid, onij, busy, done}), 64'(0));
    @(negedge clk); reset = 1'b1;

    // Run 1: OFIFO always ready; a second start mid-run must be ignored.
    fill_vp(0);
    build_model();
    run_trace(100);
    compare_model("run1");
    ref_trace = cap;
    bc = 0; ovn = 0; seq_ok = 1'b1;
    foreach (cap[i]) begin
      if (cap[i].busy && !cap[i].done) bc++;
      if (cap[i].ov) begin
        if (cap[i].onij != 4'(ovn)) seq_ok = 1'b0;
        ovn++;
      end
    end
    chk("busy_cycles", 64'(bc), 64'(1431 + 192));
    chk("out_valid_count", 64'(ovn), 64'(16));
    chk("onij_order", 64'(seq_ok), 64'(1));

    // Run 2: table run with a 5-cycle OFIFO stall in kij=2; start during DONE ignored.
    fill_vp(0);
    foreach (vecs[i]) vp[vecs[i].cyc] = vecs[i].ofv;
    build_model();
    run_trace(1628);
    compare_model("run2");
    foreach (vecs[i]) begin
      if (vecs[i].cyc < cap.size())
        chk($sformatf("vec c%0d", vecs[i].cyc),
            64'({cap[vecs[i].cyc].inst, cap[vecs[i].cyc].clr, cap[vecs[i].cyc].ov,
                 cap[vecs[i].cyc].onij, cap[vecs[i].cyc].done}),
            64'({vecs[i].inst, vecs[i].clr, vecs[i].ov, vecs[i].onij, vecs[i].done}));
      else
        chk($sformatf("vec c%0d missing", vecs[i].cyc), 64'(cap.size()), 64'(vecs[i].cyc + 1));
    end

    // Runs 3-4: random OFIFO readiness and a random ignored restart.
    for (int r = 0; r < 2; r++) begin
      fill_vp(1);
      build_model();
      run_trace(int'($urandom_range(0, 1400)));
      compare_model($sformatf("rand%0d", r));
    end

    // Asynchronous reset in the middle of EXEC; no resume afterwards.
    fill_vp(0);
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0; ofifo_valid = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk); #1;
      if (inst[1]) found = 1'b1;
    end
    chk("exec_reached", 64'(found), 64'(1));
    #1 reset = 1'b0;
    #1;
    chk("async_reset_inst", 64'(inst), 64'(IDLE));
    chk("async_reset_busy", 64'(busy), 64'(0));
    chk("async_reset_others", 64'({sfp_clr, out_valid, onij, done}), 64'(0));
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("no_resume", 64'({busy, done, inst}), 64'({1'b0, 1'b0, IDLE}));
    end
    @(negedge clk); ofifo_valid = 1'b0;

    // Run 5: fresh start must reproduce run 1 exactly.
    fill_vp(0);
    build_model();
    run_trace(-1);
    compare_model("run5");
    same = (cap.size() == ref_trace.size());
    if (same) foreach (cap[i]) if (cap[i] !== ref_trace[i]) same = 1'b0;
    chk("rerun_identical", 64'(same), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
